// File: rtl/tile_result_drain.sv
// Deskews one systolic-array result tile into a local store
// and streams it to the host row-major over valid/ready.
module tile_result_drain #(
  parameter int ACC_WIDTH = 16,
  parameter int ROWS      = 4,
  parameter int COLS      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_C,
  input  logic [COLS*ACC_WIDTH-1:0] psum_in,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [$clog2(ROWS)-1:0]   out_row,
  output logic [$clog2(COLS)-1:0]   out_col,
  output logic                      busy,
  output logic                      done,
  output logic                      err_overrun
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int N  = ROWS * COLS;
  localparam int KW = $clog2(N);
  localparam int NW = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STREAM
  } state_t;

  state_t                state_q, state_d;
  logic [NW-1:0]         cap_q, cap_d;
  logic [ACC_WIDTH-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [ACC_WIDTH-1:0]  mem [N];

  logic [RW-1:0]         nr;
  logic [CW-1:0]         nc;
  logic [KW-1:0]         nidx;

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign out_row     = row_q;
  assign out_col     = col_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err_overrun = err_q;

  // Row-major successor of the element currently presented.
  always_comb begin
    nr = row_q;
    nc = col_q + CW'(1);
    if (col_q == CW'(COLS - 1)) begin
      nc = '0;
      nr = row_q + RW'(1);
    end
    nidx = KW'(int'(nr) * COLS + int'(nc));
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    err_d   = in_valid_C && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (in_valid_C) begin
          cap_d   = NW'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        cap_d = cap_q + NW'(1);
        if (cap_q == NW'(ROWS + COLS - 2)) begin
          state_d = STREAM;
          valid_d = 1'b1;
          data_d  = mem[0];
          row_d   = '0;
          col_d   = '0;
          last_d  = (N == 1);
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            data_d  = '0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            row_d  = nr;
            col_d  = nc;
            data_d = mem[nidx];
            last_d = (nr == RW'(ROWS - 1)) &&
                     (nc == CW'(COLS - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Lane c carries row (cap - c) of its column on this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == IDLE && in_valid_C) begin
        mem[0] <= psum_in[0 +: ACC_WIDTH];
      end else if (state_q == CAPTURE) begin
        for (int c = 0; c < COLS; c++) begin
          if (int'(cap_q) >= c && int'(cap_q) - c < ROWS) begin
            mem[KW'((int'(cap_q) - c) * COLS + c)] <=
              psum_in[c*ACC_WIDTH +: ACC_WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_result_drain.sv
// Directed scenario table for tile_result_drain:
// capture deskew, stream order, stalls, overrun, reset.
module tb_tile_result_drain;

  localparam int W = 16;
  localparam int R = 4;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid_C = 1'b0;
  logic           out_ready = 1'b0;
  logic [C*W-1:0] psum_in = '0;
  logic [W-1:0]   out_data;
  logic           out_valid, out_last, busy, done, err_overrun;
  logic [1:0]     out_row, out_col;

  always #5 clk = ~clk;

  tile_result_drain #(.ACC_WIDTH(W), .ROWS(R), .COLS(C)) dut (
    .clk(clk), .rst(rst), .in_valid_C(in_valid_C),
    .psum_in(psum_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_row(out_row),
    .out_col(out_col), .busy(busy), .done(done),
    .err_overrun(err_overrun)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lane_val(int t, int c,
                                            int base, bit dsk);
    int r = t - c;
    if (r >= 0 && r < R)
      return dsk ? 16'h0000 : W'(base + r * 16 + c + 1);
    return dsk ? 16'hFFFF : 16'hDEAD;
  endfunction

  function automatic logic [W-1:0] exp_elem(int n, int base,
                                            bit dsk);
    return dsk ? 16'h0000 : W'(base + (n / C) * 16 + (n % C) + 1);
  endfunction

  task automatic drive(input int t, input int base, input bit dsk,
                       input bit strobe, input bit rdy);
    in_valid_C = strobe;
    out_ready  = rdy;
    for (int c = 0; c < C; c++)
      psum_in[c*W +: W] = lane_val(t, c, base, dsk);
  endtask

  typedef struct {
    int base;
    bit dsk;
    bit bp;
    int ov_t;
    bit ov_s;
    int rst_after;
    bit chain;
    int next_base;
    int done_t;
  } vec_t;

  vec_t tbl [8];

  task automatic run(input vec_t v, input bit pre,
                     output bit chained);
    int n = 0;
    bit stall = 0;
    bit last_hs = 0;
    bit rdy, strobe, ev;
    logic [W-1:0] pd;
    logic [1:0] pr, pc;
    chained = 0;
    for (int t = 0; t < 200; t++) begin
      if (pre && t == 0) continue;
      @(posedge clk); #1;
      rdy = v.bp ? (t % 6 == 0 || t % 6 == 3 || t % 6 == 5) : 1'b1;
      strobe = (t == 0) || (v.ov_t >= 0 && t == v.ov_t) ||
               (v.ov_s && t == 10);
      drive(t, v.base, v.dsk, strobe, rdy);
      @(negedge clk);
      chk("busy", busy, (t >= 1) && !last_hs);
      chk("done", done, last_hs);
      ev = (v.ov_t >= 0 && t - 1 == v.ov_t) || (v.ov_s && t == 11);
      chk("err_overrun", err_overrun, ev);
      if (t <= 7) chk("valid_start", out_valid, t == 7);
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
        chk("stall_row", out_row, pr);
        chk("stall_col", out_col, pc);
      end
      if (last_hs) begin
        if (v.done_t >= 0) chk("done_time", t, v.done_t);
        chk("beats", n, R * C);
        chk("valid_after_done", out_valid, 0);
        if (v.chain) begin
          drive(0, v.next_base, 1'b0, 1'b1, 1'b1);
          chained = 1;
        end
        return;
      end
      stall = out_valid && !out_ready;
      pd = out_data;
      pr = out_row;
      pc = out_col;
      if (out_valid && out_ready) begin
        chk("data", out_data, exp_elem(n, v.base, v.dsk));
        chk("row", out_row, n / C);
        chk("col", out_col, n % C);
        chk("last", out_last, n == R * C - 1);
        n++;
        if (n == R * C) last_hs = 1;
        if (n == v.rst_after) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          in_valid_C = 1'b0;
          @(negedge clk);
          chk("rst_valid", out_valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_data", out_data, 0);
          return;
        end
      end
    end
    checks++;
    errors++;
    $display("FAIL timeout: got no done expected done within 200");
  endtask

  initial begin
    bit pre, ch;
    //          base  dsk bp ov_t ov_s rst chain next  done_t
    tbl[0] = '{'h000, 0,  0, -1,  0,   -1, 0,    0,    23};
    tbl[1] = '{'h000, 1,  0, -1,  0,   -1, 0,    0,    23};
    tbl[2] = '{'h000, 0,  1, -1,  0,   -1, 0,    0,    -1};
    tbl[3] = '{'h000, 0,  0,  3,  1,   -1, 0,    0,    23};
    tbl[4] = '{'h050, 0,  0, -1,  0,    5, 0,    0,    -1};
    tbl[5] = '{'h100, 0,  0, -1,  0,   -1, 0,    0,    23};
    tbl[6] = '{'h200, 0,  0, -1,  0,   -1, 1,    'h300, 23};
    tbl[7] = '{'h300, 0,  0, -1,  0,   -1, 0,    0,    23};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err_overrun, 0);
    chk("reset_last", out_last, 0);
    chk("reset_data", out_data, 0);
    chk("reset_row", out_row, 0);
    chk("reset_col", out_col, 0);
    rst = 1'b0;

    pre = 0;
    for (int i = 0; i < 8; i++) begin
      run(tbl[i], pre, ch);
      pre = ch;
    end

    @(posedge clk); #1;
    drive(50, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
